// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

  // Index width for n requesters, never less than one bit
  function automatic int clogb(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int C_MAX_NREQ = 16;

  typedef enum logic {ARB, BURST} arb_state_e;

  typedef logic [clogb(C_MAX_NREQ)-1:0] req_idx_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester / FIFO write-side bundle of the arbiter
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int G_WIDTH = 8,
  parameter int G_NREQ  = 4
);
  localparam int IW = clogb(G_NREQ);

  logic [G_NREQ-1:0]         i_req;
  logic [G_NREQ*G_WIDTH-1:0] i_data;
  logic [G_NREQ-1:0]         i_lock;
  logic [G_NREQ-1:0]         o_ack;
  logic                      i_full;
  logic                      o_wr;
  logic [G_WIDTH-1:0]        o_data;
  logic [IW-1:0]             o_src;

  modport master (
    input  i_req, i_data, i_lock, i_full,
    output o_ack, o_wr, o_data, o_src
  );

  modport slave (
    output i_req, i_data, i_lock, i_full,
    input  o_ack, o_wr, o_data, o_src
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational rotating-priority encoder
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int G_NREQ = 4,
  parameter int G_IW   = clogb(G_NREQ)
) (
  input  logic [G_NREQ-1:0] req,
  input  logic [G_IW-1:0]   last,
  output logic [G_NREQ-1:0] gnt,
  output logic [G_IW-1:0]   idx,
  output logic              any
);
  int k;

  // Scan upward from last+1 with wrap; the first active requester wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int off = 1; off <= G_NREQ; off++) begin
      k = (int'(last) + off) % G_NREQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = G_IW'(k);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin FIFO write arbiter; burst lock enabled by FIFO_ARB_LOCK_EN
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int G_WIDTH     = 8,
  parameter int G_NREQ      = 4,
  parameter int G_MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int IW = clogb(G_NREQ);

  logic                r_valid;
  logic [G_WIDTH-1:0]  r_data;
  logic [IW-1:0]       r_src;
  logic [IW-1:0]       rr_last;
  logic [G_NREQ-1:0]   elig;
  logic [G_NREQ-1:0]   gnt;
  logic [IW-1:0]       w_idx;
  logic                any;
  logic                can_take;
  logic                accept;
  logic [G_WIDTH-1:0]  w_data;

`ifdef FIFO_ARB_LOCK_EN
  localparam int CW = clogb(G_MAX_BURST + 1);

  arb_state_e    state;
  logic [IW-1:0] owner;
  logic [CW-1:0] beat_cnt;

  // While a burst is locked only its owner may compete
  always_comb begin
    elig = bus.i_req;
    if (state == BURST) elig = bus.i_req & (G_NREQ'(1) << owner);
  end
`else
  assign elig = bus.i_req;
`endif

  rr_pick #(.G_NREQ(G_NREQ), .G_IW(IW)) u_pick (
    .req  (elig),
    .last (rr_last),
    .gnt  (gnt),
    .idx  (w_idx),
    .any  (any)
  );

  // The stage can take a beat when empty or when it drains this cycle
  assign can_take   = ~r_valid | ~bus.i_full;
  assign accept     = can_take & any & ~i_rst;
  assign w_data     = bus.i_data[w_idx*G_WIDTH +: G_WIDTH];
  assign bus.o_ack  = accept ? gnt : '0;
  assign bus.o_wr   = r_valid & ~bus.i_full;
  assign bus.o_data = r_data;
  assign bus.o_src  = r_src;

  // One-entry output stage and round-robin pointer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      rr_last <= IW'(G_NREQ - 1);
    end else if (accept) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_src   <= w_idx;
      rr_last <= w_idx;
    end else if (bus.o_wr) begin
      r_valid <= 1'b0;
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  // Burst FSM: enter on a locked accept, leave on unlock or when the burst is full
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ARB;
      owner    <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      case (state)
        ARB: begin
          if (bus.i_lock[w_idx] && (G_MAX_BURST > 1)) begin
            state    <= BURST;
            owner    <= w_idx;
            beat_cnt <= CW'(1);
          end
        end
        BURST: begin
          if (!bus.i_lock[owner] || (int'(beat_cnt) + 1 >= G_MAX_BURST)) begin
            state    <= ARB;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end
`endif

  // A requester must keep i_req high until its beat is acked
  assert property (@(posedge i_clk) disable iff (i_rst)
    !$past(i_rst) |-> ((($past(bus.i_req) & ~$past(bus.o_ack)) & ~bus.i_req) == '0));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.G_WIDTH(W), .G_NREQ(NR)) bus ();

  fifo_wr_arbiter #(.G_WIDTH(W), .G_NREQ(NR), .G_MAX_BURST(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  rq [NR][$];
  logic [NR-1:0] lock_v   = '0;
  logic          full_val = 1'b0;
  bit            fifo_mode = 1'b0;
  bit            rd_en     = 1'b0;
  int            fcnt      = 0;

  logic [NR-1:0] mon_ack = '0;
  logic          mon_wr  = 1'b0;
  logic [9:0]    sb [$];
  int            ack_log [$];
  int            ack_cyc [$];
  int            wr_cyc  [$];
  int            cyc = 0;
  int            n_ack = 0;
  int            n_wr = 0;

  // Monitor: scoreboard pop on each FIFO write, push on each ack
  always @(negedge clk) begin
    logic [9:0] e;
    int k;
    cyc++;
    mon_ack = bus.o_ack;
    mon_wr  = bus.o_wr;
    if (bus.o_wr === 1'b1) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      checks++;
      if (bus.i_full !== 1'b0) begin
        errors++;
        $display("FAIL wr_while_full: o_wr=1 i_full=%b, expected no write while full", bus.i_full);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: src=%0d data=%h, expected no write", bus.o_src, bus.o_data);
      end else begin
        e = sb.pop_front();
        if ({bus.o_src, bus.o_data} !== e) begin
          errors++;
          $display("FAIL sb_beat: src=%0d data=%h, expected src=%0d data=%h",
                   bus.o_src, bus.o_data, e[9:8], e[7:0]);
        end
      end
    end
    if (bus.o_ack !== '0) begin
      n_ack++;
      checks++;
      k = 0;
      for (int j = 0; j < NR; j++) if (bus.o_ack[j]) k = j;
      if ($countones(bus.o_ack) != 1 || (bus.o_ack & ~bus.i_req) != '0 || rq[k].size() == 0) begin
        errors++;
        $display("FAIL ack_valid: o_ack=%b i_req=%b, expected one-hot within i_req", bus.o_ack, bus.i_req);
      end else begin
        ack_log.push_back(k);
        ack_cyc.push_back(cyc);
        sb.push_back({2'(k), rq[k][0]});
      end
    end
  end

  task automatic drive();
    logic [NR*W-1:0] d;
    logic [NR-1:0]   r;
    d = '0;
    r = '0;
    for (int k = 0; k < NR; k++) begin
      if (rq[k].size() > 0) begin
        r[k]         = 1'b1;
        d[k*W +: W]  = rq[k][0];
      end
    end
    bus.i_req  = r;
    bus.i_data = d;
    bus.i_lock = lock_v;
    bus.i_full = fifo_mode ? (fcnt >= 3) : full_val;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    for (int k = 0; k < NR; k++)
      if (mon_ack[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    if (fifo_mode) begin
      if (mon_wr) fcnt++;
      if (rd_en && fcnt > 0) fcnt--;
    end
    drive();
  endtask

  function automatic bit idle();
    bit r;
    r = (sb.size() == 0);
    for (int k = 0; k < NR; k++) if (rq[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain();
    for (int i = 0; i < 300 && !idle(); i++) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    sb.delete();
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    drive();
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (bus.o_wr !== 1'b0 || bus.o_data !== 8'h00 || bus.o_src !== 2'd0 || bus.o_ack !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: wr=%b data=%h src=%0d ack=%b, expected 0/00/0/0000",
               bus.o_wr, bus.o_data, bus.o_src, bus.o_ack);
    end
    tick();
    #1 rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int b, bw;
    b  = ack_log.size();
    bw = wr_cyc.size();
    for (int k = 0; k < NR; k++) begin
      rq[k].push_back(8'(8'hA0 + k));
      rq[k].push_back(8'(8'hB0 + k));
    end
    drive();
    drain();
    checks++;
    if (!idle() || ack_log.size() != b + 8 || wr_cyc.size() != bw + 8) begin
      errors++;
      $display("FAIL rr_count: acks=%0d writes=%0d, expected 8 and 8", ack_log.size() - b, wr_cyc.size() - bw);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (ack_log[b+i] != i % 4) begin
          errors++;
          $display("FAIL rr_order[%0d]: requester %0d, expected %0d", i, ack_log[b+i], i % 4);
        end
        checks++;
        if (wr_cyc[bw+i] != ack_cyc[b+i] + 1) begin
          errors++;
          $display("FAIL rr_latency[%0d]: write cycle %0d, expected %0d", i, wr_cyc[bw+i], ack_cyc[b+i] + 1);
        end
      end
    end
  endtask

  task automatic test_full_hold();
    rq[0].push_back(8'h55);
    full_val = 1'b1;
    drive();
    @(negedge clk);
    checks++;
    if (bus.o_ack !== 4'b0001) begin
      errors++;
      $display("FAIL full_load_ack: o_ack=%b, expected 0001", bus.o_ack);
    end
    tick();
    rq[2].push_back(8'h77);
    drive();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_wr !== 1'b0 || bus.o_ack !== 4'b0000) begin
        errors++;
        $display("FAIL full_hold[%0d]: wr=%b ack=%b, expected 0 and 0000", i, bus.o_wr, bus.o_ack);
      end
      tick();
    end
    full_val = 1'b0;
    drive();
    @(negedge clk);
    checks++;
    if (bus.o_wr !== 1'b1 || bus.o_data !== 8'h55 || bus.o_ack !== 4'b0100) begin
      errors++;
      $display("FAIL full_release: wr=%b data=%h ack=%b, expected 1/55/0100", bus.o_wr, bus.o_data, bus.o_ack);
    end
    drain();
    checks++;
    if (!idle()) begin
      errors++;
      $display("FAIL full_drain: %0d beats in scoreboard, expected 0", sb.size());
    end
  endtask

  task automatic test_single();
    int b, bw;
    b  = ack_log.size();
    bw = wr_cyc.size();
    for (int j = 0; j < 6; j++) rq[3].push_back(8'(8'hC0 + j));
    drive();
    drain();
    checks++;
    if (ack_log.size() != b + 6 || wr_cyc.size() != bw + 6) begin
      errors++;
      $display("FAIL single_count: acks=%0d writes=%0d, expected 6 and 6", ack_log.size() - b, wr_cyc.size() - bw);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (ack_log[b+i] != 3 || ack_cyc[b+i] != ack_cyc[b] + i || wr_cyc[bw+i] != ack_cyc[b] + 1 + i) begin
          errors++;
          $display("FAIL single_stream[%0d]: req=%0d ack_cyc=%0d wr_cyc=%0d, expected 3/%0d/%0d",
                   i, ack_log[b+i], ack_cyc[b+i], wr_cyc[bw+i], ack_cyc[b] + i, ack_cyc[b] + 1 + i);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int b;
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < 4; j++) rq[k].push_back(8'(k * 16 + j + 1));
    drive();
    repeat (3) tick();
    #1;
    checks++;
    if (bus.o_wr !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: o_wr=%b, expected 1 before reset", bus.o_wr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_wr !== 1'b0 || bus.o_data !== 8'h00 || bus.o_ack !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_async: wr=%b data=%h ack=%b, expected 0/00/0000", bus.o_wr, bus.o_data, bus.o_ack);
    end
    sb.delete();
    tick();
    tick();
    #1 rst = 1'b0;
    b = ack_log.size();
    for (int i = 0; i < 10 && ack_log.size() == b; i++) tick();
    checks++;
    if (ack_log.size() == b) begin
      errors++;
      $display("FAIL reset_mid_first: no ack after release, expected requester 0");
    end else if (ack_log[b] != 0) begin
      errors++;
      $display("FAIL reset_mid_first: requester %0d, expected 0", ack_log[b]);
    end
    drain();
    checks++;
    if (!idle()) begin
      errors++;
      $display("FAIL reset_mid_drain: %0d beats in scoreboard, expected 0", sb.size());
    end
  endtask

  task automatic test_lock();
    int b;
    int exp_a [6];
    int exp_b [6];
    bit seen;
`ifdef FIFO_ARB_LOCK_EN
    exp_a = '{0, 1, 1, 1, 1, 2};
    exp_b = '{0, 1, 1, 2, 3, 0};
`else
    exp_a = '{0, 1, 2, 3, 0, 1};
    exp_b = '{0, 1, 2, 3, 0, 1};
`endif
    apply_reset();
    b = ack_log.size();
    for (int j = 0; j < 6; j++) rq[1].push_back(8'(8'h10 + j));
    for (int k = 0; k < NR; k++)
      if (k != 1) for (int j = 0; j < 2; j++) rq[k].push_back(8'(8'h40 + k * 8 + j));
    lock_v = 4'b0010;
    drive();
    for (int i = 0; i < 40 && ack_log.size() < b + 6; i++) tick();
    lock_v = '0;
    drive();
    checks++;
    if (ack_log.size() < b + 6) begin
      errors++;
      $display("FAIL lock_full_count: %0d acks, expected 6", ack_log.size() - b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (ack_log[b+i] != exp_a[i]) begin
          errors++;
          $display("FAIL lock_full[%0d]: requester %0d, expected %0d", i, ack_log[b+i], exp_a[i]);
        end
      end
    end
    drain();

    apply_reset();
    b = ack_log.size();
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < 3; j++) rq[k].push_back(8'(8'h80 + k * 8 + j));
    lock_v = 4'b0010;
    drive();
    for (int i = 0; i < 60 && !idle(); i++) begin
      tick();
      seen = 1'b0;
      for (int j = b; j < ack_log.size(); j++) if (ack_log[j] == 1) seen = 1'b1;
      if (lock_v[1] && seen) begin
        lock_v = '0;
        drive();
      end
    end
    checks++;
    if (!idle() || ack_log.size() < b + 6) begin
      errors++;
      $display("FAIL lock_drop_count: %0d acks, expected 12", ack_log.size() - b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (ack_log[b+i] != exp_b[i]) begin
          errors++;
          $display("FAIL lock_drop[%0d]: requester %0d, expected %0d", i, ack_log[b+i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_fifo_overflow();
    int a0, w0;
    apply_reset();
    fcnt      = 0;
    rd_en     = 1'b0;
    fifo_mode = 1'b1;
    a0 = n_ack;
    w0 = n_wr;
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < 3; j++) rq[k].push_back(8'(8'hE0 + k * 4 + j));
    drive();
    repeat (20) tick();
    checks++;
    if (n_ack - a0 != 4 || n_wr - w0 != 3 || fcnt != 3) begin
      errors++;
      $display("FAIL fifo_stall: acks=%0d writes=%0d fill=%0d, expected 4/3/3", n_ack - a0, n_wr - w0, fcnt);
    end
    rd_en = 1'b1;
    drain();
    checks++;
    if (!idle() || n_ack - a0 != 12 || n_wr - w0 != 12) begin
      errors++;
      $display("FAIL fifo_resume: acks=%0d writes=%0d, expected 12/12", n_ack - a0, n_wr - w0);
    end
    fifo_mode = 1'b0;
    rd_en     = 1'b0;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_full_hold();
    test_single();
    test_reset_mid();
    test_lock();
    test_fifo_overflow();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
